// File: rtl/cordic_vec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vec_pipe
// Description : Fully pipelined vectoring-mode CORDIC. Converts a signed
//               fixed-point (x, y) pair into magnitude and atan2 phase, one
//               vector per enabled cycle, latency ITER+2 enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vec_pipe #(
  parameter int     W      = 37,
  parameter int     FRAC   = 27,
  parameter int     ITER   = 16,
  parameter longint K_GAIN = 81504109
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                in_valid,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic                out_valid,
  output logic signed [W-1:0] mag_out,
  output logic signed [W-1:0] phase_out
);

  // x/y carry two guard bits for the CORDIC gain (~1.647 * sqrt(2))
  localparam int XW   = W + 2;
  localparam int PW   = XW + W;
  localparam int NTAB = 24;

  // atan(2^-i) in radians, i = 0..23
  function automatic real atan_real(input int i);
    case (i)
      0:  atan_real = 0.7853981633974483;
      1:  atan_real = 0.4636476090008061;
      2:  atan_real = 0.24497866312686414;
      3:  atan_real = 0.12435499454676144;
      4:  atan_real = 0.06241880999595735;
      5:  atan_real = 0.031239833430268277;
      6:  atan_real = 0.015623728620476831;
      7:  atan_real = 0.007812341060101111;
      8:  atan_real = 0.0039062301319669718;
      9:  atan_real = 0.0019531225164788188;
      10: atan_real = 0.0009765621895593195;
      11: atan_real = 0.0004882812111948983;
      12: atan_real = 0.00024414062014936177;
      13: atan_real = 0.00012207031189367021;
      14: atan_real = 6.103515617420877e-05;
      15: atan_real = 3.0517578115526096e-05;
      16: atan_real = 1.5258789061315762e-05;
      17: atan_real = 7.62939453110197e-06;
      18: atan_real = 3.814697265606496e-06;
      19: atan_real = 1.907348632810187e-06;
      20: atan_real = 9.536743164059608e-07;
      21: atan_real = 4.7683715820308884e-07;
      22: atan_real = 2.3841857910155797e-07;
      23: atan_real = 1.1920928955078068e-07;
      default: atan_real = 0.0;
    endcase
  endfunction

  // Rounded fixed-point angle table, packed W bits per entry
  function automatic logic [NTAB*W-1:0] build_atan_tab();
    logic [NTAB*W-1:0] t;
    t = '0;
    for (int i = 0; i < NTAB; i++) begin
      t[i*W +: W] = W'(longint'(atan_real(i) * (2.0 ** FRAC)));
    end
    return t;
  endfunction

  localparam logic [NTAB*W-1:0]    ATAN_TAB  = build_atan_tab();
  localparam logic signed [W-1:0]  PI_FX     = W'(longint'(3.141592653589793 * (2.0 ** FRAC)));
  localparam logic signed [W-1:0]  K_FX      = W'(K_GAIN);
  localparam logic signed [W-1:0]  MAG_MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MAG_MAX_P = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] HALF_LSB  = PW'(longint'(1) <<< (FRAC-1));

  // Two's-complement negate that maps the most negative code to the most positive
  function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] v);
    if (v == {1'b1, {(W-1){1'b0}}}) sat_neg = MAG_MAX_W;
    else                            sat_neg = -v;
  endfunction

  // Index 0 holds the pre-rotated vector, index i+1 the output of micro-rotation i
  logic signed [XW-1:0] x_d [0:ITER];
  logic signed [XW-1:0] x_q [0:ITER];
  logic signed [XW-1:0] y_d [0:ITER];
  logic signed [XW-1:0] y_q [0:ITER];
  logic signed [W-1:0]  z_d [0:ITER];
  logic signed [W-1:0]  z_q [0:ITER];
  logic [ITER:0]        zero_d, zero_q;
  logic [ITER+1:0]      vld_d, vld_q;
  logic signed [W-1:0]  mag_d, mag_q;
  logic signed [W-1:0]  phase_d, phase_q;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_rnd;

  // Next-state for every pipeline stage: pre-rotation, micro-rotations, gain/round/saturate
  always_comb begin
    if (x_in[W-1]) begin
      x_d[0] = XW'(sat_neg(x_in));
      y_d[0] = XW'(sat_neg(y_in));
      z_d[0] = y_in[W-1] ? -PI_FX : PI_FX;
    end else begin
      x_d[0] = XW'(x_in);
      y_d[0] = XW'(y_in);
      z_d[0] = '0;
    end
    zero_d[0] = (x_in == '0) && (y_in == '0);

    for (int i = 0; i < ITER; i++) begin
      if (!y_q[i][XW-1]) begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        y_d[i+1] = y_q[i] - (x_q[i] >>> i);
        z_d[i+1] = z_q[i] + $signed(ATAN_TAB[i*W +: W]);
      end else begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        y_d[i+1] = y_q[i] + (x_q[i] >>> i);
        z_d[i+1] = z_q[i] - $signed(ATAN_TAB[i*W +: W]);
      end
      zero_d[i+1] = zero_q[i];
    end

    // x is non-negative after pre-rotation; the negative clamp only keeps the output defined
    prod     = PW'(x_q[ITER]) * PW'(K_FX);
    prod_rnd = (prod + HALF_LSB) >>> FRAC;
    if (prod_rnd[PW-1])             mag_d = '0;
    else if (prod_rnd > MAG_MAX_P)  mag_d = MAG_MAX_W;
    else                            mag_d = prod_rnd[W-1:0];

    phase_d = zero_q[ITER] ? '0 : z_q[ITER];
    vld_d   = {vld_q[ITER:0], in_valid};
  end

  // Pipeline registers: asynchronous clear, advance only on enabled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ITER; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
      zero_q  <= '0;
      vld_q   <= '0;
      mag_q   <= '0;
      phase_q <= '0;
    end else if (ce) begin
      for (int i = 0; i <= ITER; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
        z_q[i] <= z_d[i];
      end
      zero_q  <= zero_d;
      vld_q   <= vld_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
    end
  end

  assign out_valid = vld_q[ITER+1];
  assign mag_out   = mag_q;
  assign phase_out = phase_q;

endmodule
`default_nettype wire

// File: doc/cordic_vec_pipe.md
CORDIC_VEC_PIPE -- requirements
Module: cordic_vec_pipe

Interface
REQ-001 SHALL have parameter W, default 37: signed input/output word width, legal 30..48.
REQ-002 SHALL have parameter FRAC, default 27: fractional bits of all fixed-point ports, legal 16..W-6.
REQ-003 SHALL have parameter ITER, default 16: micro-rotation stages, legal 8..24.
REQ-004 SHALL have parameter K_GAIN, default 81504109: round(0.607252935*2^FRAC), the gain-compensation constant for ITER>=16.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 ce  input  1  clock enable; low freezes the whole pipeline including valid bits.
REQ-008 in_valid  input  1  qualifies x_in/y_in on this cycle.
REQ-009 x_in  input  W  signed x, Q(W-FRAC).FRAC.
REQ-010 y_in  input  W  signed y, same format.
REQ-011 out_valid  output  1  qualifies mag_out/phase_out.
REQ-012 mag_out  output  W  sqrt(x^2+y^2), unsigned value in signed word, same format.
REQ-013 phase_out  output  W  atan2(y,x) in radians, signed, same format, range [-pi, +pi].

Function
REQ-014 Stage 0 SHALL register the pre-rotated vector: x>=0 -> (x, y, z=0); x<0 -> (-x, -y, z=+pi if y>=0 else -pi).
REQ-015 Negating -2^(W-1) SHALL saturate to 2^(W-1)-1.
REQ-016 Internal x/y datapath SHALL be W+2 bits signed; z datapath W bits signed; all shifts arithmetic.
REQ-017 Stage i (i=0..ITER-1): if y_i>=0 then x+=y>>>i, y-=x>>>i, z+=atan(2^-i); else x-=y>>>i, y+=x>>>i, z-=atan(2^-i); all using stage-i inputs.
REQ-018 atan(2^-i) constants SHALL be a 24-entry localparam table rounded to FRAC bits; pi rounded to FRAC bits.
REQ-019 Final stage SHALL multiply x_ITER by K_GAIN, drop FRAC bits with round-half-up, saturate to 2^(W-1)-1, register to mag_out.
REQ-020 phase_out SHALL be z_ITER registered alongside mag_out.
REQ-021 Latency SHALL be ITER+2 enabled cycles from in_valid sample to out_valid; throughput one vector per enabled cycle.
REQ-022 in_valid SHALL propagate through a (ITER+2)-bit shift register advancing only when ce=1; data stages also advance only when ce=1.
REQ-023 Data stages SHALL advance regardless of in_valid; outputs with out_valid=0 are don't-care but SHALL be deterministic.
REQ-024 x_in=y_in=0 SHALL produce mag_out=0, phase_out=0 (stage-0 zero flag carried down the pipe forces phase to 0).
REQ-025 x_in<0, y_in=0 SHALL produce phase_out=+pi.
REQ-026 Accuracy: mag_out within 2^-(ITER-2) relative + 4 LSB; phase_out within 2^-(ITER-1) rad + ITER LSB.
REQ-027 ce=0 with in_valid=1 SHALL ignore the input; no sample is captured.

Reset
REQ-028 rst_n low SHALL asynchronously clear all stage registers, valid shift register, out_valid, mag_out, phase_out to 0.
REQ-029 Reset mid-stream SHALL discard all in-flight vectors; first out_valid after release occurs exactly ITER+2 enabled cycles after the first accepted in_valid.
REQ-030 Release of rst_n SHALL be used synchronously; no output glitch on the releasing edge.

Verification (defaults W=37, FRAC=27, ITER=16, ce=1)
REQ-031 x=3.0 (402653184), y=4.0 (536870912), in_valid one cycle -> out_valid exactly 18 cycles later, mag_out ~671088640 (5.0), phase_out ~124459000 (0.927295 rad), within REQ-026.
REQ-032 x=-1.0, y=0 -> mag ~1.0 (134217728), phase_out ~+pi (421657428); x=-1.0, y=-2^-27 -> phase ~-pi.
REQ-033 x=y=0 -> mag_out=0, phase_out=0 exactly.
REQ-034 back-to-back 100 random vectors with |x|,|y|<2^(W-FRAC-3) -> 100 consecutive out_valid pulses, each vs real-valued model within REQ-026.
REQ-035 ce toggled pseudo-randomly during stream -> same result sequence as ce=1, latency counted in enabled cycles only.
REQ-036 rst_n pulsed low for 1 cycle with 5 vectors in flight -> outputs 0 immediately, no out_valid until 18 cycles after next accepted vector.
